seq_stage_controller: RTL
=========================

Name: seq_stage_controller

Overview:
Sequences the single-cycle-per-stage SEQ processor through its stages: fetch, decode, execute, memory, writeback and PC update. Owns the architectural PC register and the processor status code. Pulses one stage enable at a time. Selects the next PC from the fetch, execute and memory results. Stops the machine on halt, invalid instruction or address error.

Parameters:
PC_RESET, 64'd0, PC value loaded on reset.
MEM_TIMEOUT, 8, max cycles to wait for mem_ready before raising ADR; range 1..255.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  level; leaves IDLE when high
icode  in  4  from fetch, valid in DECODE onward
valC  in  64  from fetch
valP  in  64  from fetch
valM  in  64  from memory stage, valid when mem_ready high
cnd  in  1  branch condition from execute, valid in MEMORY onward
hlt  in  1  fetch halt flag
ins_address  in  1  fetch invalid-instruction flag
adr_address  in  1  fetch address-error flag
mem_ready  in  1  memory stage completion
pc  out  64  architectural PC, fed to fetch
fetch_en, decode_en, execute_en, memory_en, writeback_en  out  1 each  one-hot stage pulses
stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
running  out  1  high in any state except IDLE and HALTED

Behaviour:
- Reset values: pc=PC_RESET; stat=AOK; all enables 0; running 0; state IDLE. Reset mid-operation aborts immediately with no partial PC update.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED.
- IDLE -> FETCH when start=1.
- FETCH: fetch_en=1 for one cycle. Fetch outputs are registered, so they are sampled in DECODE.
- DECODE: error checks, priority adr_address > ins_address > hlt:
  - adr_address -> stat=ADR, go to HALTED.
  - ins_address -> stat=INS, go to HALTED.
  - hlt -> stat=HLT, go to HALTED.
  - None set -> decode_en=1, go to EXECUTE.
  - On halt, pc is held at the address of the offending instruction.
- EXECUTE: execute_en=1, go to MEMORY.
- MEMORY: memory_en held high.
  - Memory icodes (4,5,8,9,A,B): wait until mem_ready=1, then go to WRITEBACK.
  - Timeout counter starts at 0 on MEMORY entry. If MEM_TIMEOUT cycles pass without mem_ready -> stat=ADR, go to HALTED.
  - Non-memory icodes: one cycle only, mem_ready ignored.
- WRITEBACK: writeback_en=1, go to PCUPD.
- PCUPD: no enables. pc updated on this clock edge:
  - icode 7 and cnd=1 -> valC
  - icode 8 -> valC
  - icode 9 -> valM (latched when mem_ready was accepted)
  - otherwise -> valP
  - Then go to FETCH.
- HALTED: sticky. Only reset exits. start is ignored. All enables 0.
- Instruction latency: 6 cycles (FETCH..PCUPD) with no memory stall.
- PC arithmetic is 64-bit with no overflow check; wrap is the fetch stage's concern via adr_address.
- At most one *_en high in any cycle.

Optional Feature:
SEQ_PERF_COUNTERS_EN
- Defined: adds outputs cycle_count[63:0] and instr_count[63:0], both reset to 0.
  - cycle_count increments every cycle while running=1.
  - instr_count increments on every PCUPD cycle.
  - Both saturate at all-ones and freeze in HALTED.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package seq_pkg holds:
  - icode constants: HALT=0, NOP=1, CMOV=2, IRMOV=3, RMMOV=4, MRMOV=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSH=A, POP=B.
  - stat codes AOK/HLT/ADR/INS.
  - state enum.
  - is_mem_icode function.
- One natural sub-module: seq_next_pc, a combinational next-PC mux (icode, cnd, valC, valP, valM -> next_pc). The FSM, timeout counter and PC register stay in the top module.

Test Plan:
- Reset, then start=1 with icode=1, valP=PC+1, no flags -> enables pulse in order F,D,E,M,W over 5 cycles; on the 6th cycle pc=1; stat=1.
- icode=7, cnd=1, valC=0x40 -> pc=0x40 after PCUPD. Same with cnd=0, valP=0x09 -> pc=0x09.
- icode=9, mem_ready delayed 3 cycles, valM=0x20 -> memory_en high 4 cycles, pc=0x20, latency 9 cycles.
- hlt=1 and ins_address=1 together in DECODE -> stat=4, HALTED, pc unchanged; a later start pulse leaves pc and stat unchanged.
- icode=5, mem_ready held 0 -> after MEM_TIMEOUT=8 cycles stat=3, running=0; reset then restores pc=PC_RESET and stat=1.
- With SEQ_PERF_COUNTERS_EN defined: 3 NOPs then halt -> instr_count=3; cycle_count=3*6+2 (FETCH+DECODE of the halt instruction).

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared icode, status and state constants for the SEQ stage controller
package seq_pkg;
    localparam logic [3:0] ICODE_HALT  = 4'h0;
    localparam logic [3:0] ICODE_NOP   = 4'h1;
    localparam logic [3:0] ICODE_CMOV  = 4'h2;
    localparam logic [3:0] ICODE_IRMOV = 4'h3;
    localparam logic [3:0] ICODE_RMMOV = 4'h4;
    localparam logic [3:0] ICODE_MRMOV = 4'h5;
    localparam logic [3:0] ICODE_OPQ   = 4'h6;
    localparam logic [3:0] ICODE_JXX   = 4'h7;
    localparam logic [3:0] ICODE_CALL  = 4'h8;
    localparam logic [3:0] ICODE_RET   = 4'h9;
    localparam logic [3:0] ICODE_PUSH  = 4'hA;
    localparam logic [3:0] ICODE_POP   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_FETCH     = 3'd1;
    localparam state_t S_DECODE    = 3'd2;
    localparam state_t S_EXECUTE   = 3'd3;
    localparam state_t S_MEMORY    = 3'd4;
    localparam state_t S_WRITEBACK = 3'd5;
    localparam state_t S_PCUPD     = 3'd6;
    localparam state_t S_HALTED    = 3'd7;

    function automatic logic is_mem_icode(input logic [3:0] icode);
        return icode inside {ICODE_RMMOV, ICODE_MRMOV, ICODE_CALL, ICODE_RET, ICODE_PUSH, ICODE_POP};
    endfunction
endpackage

// File: rtl/seq_next_pc.sv
// seq_next_pc: combinational next-PC select from fetch, execute and memory results
module seq_next_pc
    import seq_pkg::*;
(
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valM,
    output logic [63:0] next_pc
);
    // taken jumps and calls go to valC, returns to the popped address, all else falls through
    always_comb begin
        next_pc = ((icode == ICODE_JXX && cnd) || icode == ICODE_CALL) ? valC :
                  (icode == ICODE_RET) ? valM : valP;
    end
endmodule

// File: rtl/seq_stage_controller.sv
// seq_stage_controller: SEQ stage sequencer owning PC and status; optional SEQ_PERF_COUNTERS_EN adds cycle/instr counters
module seq_stage_controller
    import seq_pkg::*;
#(
    parameter logic [63:0] PC_RESET    = 64'd0,
    parameter int          MEM_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic [63:0] valM,
    input  logic        cnd,
    input  logic        hlt,
    input  logic        ins_address,
    input  logic        adr_address,
    input  logic        mem_ready,
    output logic [63:0] pc,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        execute_en,
    output logic        memory_en,
    output logic        writeback_en,
    output logic [2:0]  stat,
    output logic        running
`ifdef SEQ_PERF_COUNTERS_EN
    ,
    output logic [63:0] cycle_count,
    output logic [63:0] instr_count
`endif
);
    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [2:0]  stat_q, stat_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [63:0] valm_q, valm_d;
    logic [63:0] next_pc;

    seq_next_pc u_next_pc (
        .icode   (icode),
        .cnd     (cnd),
        .valC    (valC),
        .valP    (valP),
        .valM    (valm_q),
        .next_pc (next_pc)
    );

    // stage sequencing, error capture, memory timeout and PC update selection
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stat_d  = stat_q;
        tmo_d   = tmo_q;
        valm_d  = valm_q;
        case (state_q)
            S_IDLE:      state_d = start ? S_FETCH : S_IDLE;
            S_FETCH:     state_d = S_DECODE;
            S_DECODE: begin
                stat_d  = adr_address ? STAT_ADR : ins_address ? STAT_INS : hlt ? STAT_HLT : stat_q;
                state_d = (adr_address || ins_address || hlt) ? S_HALTED : S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_MEMORY;
                tmo_d   = 8'd0;
            end
            S_MEMORY: begin
                if (!is_mem_icode(icode)) begin
                    state_d = S_WRITEBACK;
                end else if (mem_ready) begin
                    valm_d  = valM;
                    state_d = S_WRITEBACK;
                end else if (tmo_q == 8'(MEM_TIMEOUT - 1)) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALTED;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD: begin
                pc_d    = next_pc;
                state_d = S_FETCH;
            end
            default:     state_d = S_HALTED;
        endcase
    end

    // architectural state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            stat_q  <= STAT_AOK;
            tmo_q   <= 8'd0;
            valm_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stat_q  <= stat_d;
            tmo_q   <= tmo_d;
            valm_q  <= valm_d;
        end
    end

    // one-hot stage enables decoded from the current state
    always_comb begin
        fetch_en     = state_q == S_FETCH;
        decode_en    = state_q == S_DECODE && !(adr_address || ins_address || hlt);
        execute_en   = state_q == S_EXECUTE;
        memory_en    = state_q == S_MEMORY;
        writeback_en = state_q == S_WRITEBACK;
        running      = state_q != S_IDLE && state_q != S_HALTED;
        pc           = pc_q;
        stat         = stat_q;
    end

`ifdef SEQ_PERF_COUNTERS_EN
    logic [63:0] cyc_q, cyc_d, ins_q, ins_d;

    // saturating counters; both stop naturally once the machine is halted
    always_comb begin
        cyc_d = (running && ~&cyc_q) ? cyc_q + 64'd1 : cyc_q;
        ins_d = (state_q == S_PCUPD && ~&ins_q) ? ins_q + 64'd1 : ins_q;
    end

    // counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= 64'd0;
            ins_q <= 64'd0;
        end else begin
            cyc_q <= cyc_d;
            ins_q <= ins_d;
        end
    end

    assign cycle_count = cyc_q;
    assign instr_count = ins_q;
`endif
endmodule
